// File: rtl/ahb_to_iop_bridge_ws_if.sv
// ----------------------------------------------------------------------------
// ahb_to_iop_bridge_ws_if
// Bundles the AHB-Lite slave-side signals and the IOP peripheral bus used by
// ahb_to_iop_bridge_ws.
//
// Parameters : ADDR_WIDTH (HADDR/IOADDR), DATA_WIDTH (all data buses, 32/64)
// Modports   : slave  - the bridge view (AHB inputs, HREADYOUT/HRESP/HRDATA
//                       out; IORDATA/IOREADY/IOERROR in, IOP controls out)
//              master - the opposite view, used by the bus mux, the
//                       peripherals or a testbench
// ----------------------------------------------------------------------------
interface ahb_to_iop_bridge_ws_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   // AHB-Lite slave side
   logic                  HSEL;
   logic                  HREADY;
   logic [1:0]            HTRANS;
   logic [2:0]            HSIZE;
   logic                  HWRITE;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADYOUT;
   logic                  HRESP;
   logic [DATA_WIDTH-1:0] HRDATA;

   // IOP peripheral side
   logic [DATA_WIDTH-1:0] IORDATA;
   logic                  IOREADY;
   logic                  IOERROR;
   logic                  IOSEL;
   logic                  IOTRANS;
   logic [ADDR_WIDTH-1:0] IOADDR;
   logic                  IOWRITE;
   logic [1:0]            IOSIZE;
   logic [DATA_WIDTH-1:0] IOWDATA;

   modport slave (
      input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
      output HREADYOUT, HRESP, HRDATA,
      input  IORDATA, IOREADY, IOERROR,
      output IOSEL, IOTRANS, IOADDR, IOWRITE, IOSIZE, IOWDATA
   );

   modport master (
      output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
      input  HREADYOUT, HRESP, HRDATA,
      output IORDATA, IOREADY, IOERROR,
      input  IOSEL, IOTRANS, IOADDR, IOWRITE, IOSIZE, IOWDATA
   );
endinterface

// File: rtl/ahb_to_iop_bridge_ws.sv
// ----------------------------------------------------------------------------
// ahb_to_iop_bridge_ws
// AHB-Lite slave to IOP bridge with wait states and error responses. The
// address phase is registered onto the IOP bus; the AHB data phase is
// stretched until IOREADY. IOERROR, or TIMEOUT_CYCLES data-phase cycles
// without IOREADY, becomes a two-cycle AHB ERROR response.
//
// Ports:
//   HCLK     in  bus clock
//   HRESETn  in  asynchronous active-low reset
//   bus      ahb_to_iop_bridge_ws_if.slave (AHB + IOP signals)
//
// Parameters: ADDR_WIDTH (12), DATA_WIDTH (32, must be 32 or 64),
//             TIMEOUT_CYCLES (16, 0 disables the timeout)
//
// Optional macro AHB_TO_IOP_RDATA_REG_EN: read data is registered and
// returned from an extra RDHOLD state (one extra wait state on reads only).
// ----------------------------------------------------------------------------
module ahb_to_iop_bridge_ws #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                   HCLK,
   input logic                   HRESETn,
   ahb_to_iop_bridge_ws_if.slave bus
);

   // Counter is wide enough to reach TIMEOUT_CYCLES; kept at least 1 bit so
   // the disabled-timeout build still elaborates.
   localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_ERR1,
      S_ERR2,
      S_RDHOLD
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic                  r_hresp;
   logic                  r_iosel;
   logic                  r_iotrans;
   logic [ADDR_WIDTH-1:0] r_ioaddr;
   logic                  r_iowrite;
   logic [1:0]            r_iosize;

   logic w_done;
   logic w_timeout;
   logic w_rd_hold;
   logic w_hreadyout;
   logic w_accept;
   logic w_unused;

   // IOERROR only counts when qualified by IOREADY.
   assign w_done    = bus.IOREADY & ~bus.IOERROR;
   // Fires on the TIMEOUT_CYCLES-th consecutive cycle without IOREADY.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && !bus.IOREADY && (r_wait_cnt == CNT_LAST);

`ifdef AHB_TO_IOP_RDATA_REG_EN
   logic [DATA_WIDTH-1:0] r_rdata;

   // A completing read detours through RDHOLD to present registered data.
   assign w_rd_hold = ~r_iowrite;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_rdata <= '0;
      end else if (r_state == S_ACCESS && w_done && !r_iowrite) begin
         r_rdata <= bus.IORDATA;
      end
   end

   assign bus.HRDATA = r_rdata;
`else
   assign w_rd_hold  = 1'b0;
   assign bus.HRDATA = bus.IORDATA;
`endif

   // NOTE: every variable written in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      w_hreadyout = 1'b1;
      case (r_state)
         S_ACCESS: w_hreadyout = w_done & ~w_timeout & ~w_rd_hold;
         S_ERR1:   w_hreadyout = 1'b0;
         default:  w_hreadyout = 1'b1;
      endcase
   end

   assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & w_hreadyout;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_hresp    <= 1'b0;
         r_iosel    <= 1'b0;
         r_iotrans  <= 1'b0;
         r_ioaddr   <= '0;
         r_iowrite  <= 1'b0;
         r_iosize   <= '0;
      end else begin
         // Address phase is captured only when the AHB bus is advancing.
         if (w_hreadyout) begin
            r_iosel   <= bus.HSEL & bus.HREADY;
            r_iotrans <= w_accept;
            r_ioaddr  <= bus.HADDR;
            r_iowrite <= bus.HWRITE;
            r_iosize  <= bus.HSIZE[1:0];
         end

         case (r_state)
            S_IDLE, S_ERR2, S_RDHOLD: begin
               r_state    <= w_accept ? S_ACCESS : S_IDLE;
               r_wait_cnt <= '0;
               r_hresp    <= 1'b0;
            end

            S_ACCESS: begin
               if (bus.IOREADY) begin
                  r_wait_cnt <= '0;
                  if (bus.IOERROR) begin
                     r_state   <= S_ERR1;
                     r_hresp   <= 1'b1;
                     r_iotrans <= 1'b0;
                  end else if (w_rd_hold) begin
                     r_state <= S_RDHOLD;
                  end else begin
                     r_state <= w_accept ? S_ACCESS : S_IDLE;
                  end
               end else begin
                  if (r_wait_cnt != CNT_MAX) begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
                  if (w_timeout) begin
                     r_state   <= S_ERR1;
                     r_hresp   <= 1'b1;
                     r_iotrans <= 1'b0;
                  end
               end
            end

            // HRESP stays high through ERR2; it is cleared on leaving ERR2.
            S_ERR1:  r_state <= S_ERR2;

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.HREADYOUT = w_hreadyout;
   assign bus.HRESP     = r_hresp;
   assign bus.IOSEL     = r_iosel;
   assign bus.IOTRANS   = r_iotrans;
   assign bus.IOADDR    = r_ioaddr;
   assign bus.IOWRITE   = r_iowrite;
   assign bus.IOSIZE    = r_iosize;
   assign bus.IOWDATA   = bus.HWDATA;

   // HSIZE[2] and HTRANS[0] carry no information for this bridge.
   assign w_unused = ^{bus.HSIZE[2], bus.HTRANS[0]};

endmodule

// File: doc/ahb_to_iop_bridge_ws.md
Name: ahb_to_iop_bridge_ws

Overview:
- Parametrised AHB-Lite slave to IOP bridge with wait-state and error support.
- Sits between the AHB slave mux and IOP peripherals such as GPIO and timers. Replaces the fixed zero-wait, 12-bit bridge.
- Registers the address phase onto the IOP bus and stretches the AHB data phase until the peripheral asserts IOREADY.
- Converts IOERROR, or a no-response timeout, into a standard two-cycle AHB ERROR response.

Parameters:
- ADDR_WIDTH, 12: width of HADDR and IOADDR.
- DATA_WIDTH, 32: width of HWDATA, HRDATA, IOWDATA and IORDATA. Must be 32 or 64.
- TIMEOUT_CYCLES, 16: maximum data-phase cycles waiting for IOREADY before an ERROR response. 0 disables the timeout.

Ports:
- HCLK  in  1  system bus clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  AHB slave select.
- HREADY  in  1  AHB ready from the bus.
- HTRANS  in  2  AHB transfer type.
- HSIZE  in  3  AHB transfer size.
- HWRITE  in  1  AHB direction.
- HADDR  in  ADDR_WIDTH  AHB address.
- HWDATA  in  DATA_WIDTH  AHB write data.
- HREADYOUT  out  1  slave ready to the S->M mux.
- HRESP  out  1  slave response; 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- IORDATA  in  DATA_WIDTH  IOP read data.
- IOREADY  in  1  IOP transfer complete.
- IOERROR  in  1  IOP error; sampled only together with IOREADY.
- IOSEL  out  1  registered select.
- IOTRANS  out  1  IOP transfer active.
- IOADDR  out  ADDR_WIDTH  registered address.
- IOWRITE  out  1  registered direction.
- IOSIZE  out  2  registered HSIZE[1:0].
- IOWDATA  out  DATA_WIDTH  write data, equal to HWDATA combinationally.

Behaviour:
- Clocking and reset: clock is HCLK. Reset is HRESETn, asynchronous, active-low.
- Reset values: state=IDLE, wait counter=0, IOSEL=0, IOTRANS=0, IOADDR=0, IOWRITE=0, IOSIZE=0. HREADYOUT=1, HRESP=0.
- Accept condition: accept = HSEL & HREADY & HTRANS[1] & HREADYOUT.
  - Evaluated in IDLE, in the completing ACCESS cycle, and in ERR2.
- Address-phase register: on every edge where HREADYOUT=1, register:
  - IOSEL <= HSEL & HREADY
  - IOTRANS <= accept
  - IOADDR <= HADDR
  - IOWRITE <= HWRITE
  - IOSIZE <= HSIZE[1:0]
  When HREADYOUT=0, these registers hold.
- FSM, IDLE: HREADYOUT=1, HRESP=0. accept -> ACCESS, counter cleared.
- FSM, ACCESS:
  - HREADYOUT = IOREADY & ~IOERROR & ~timeout.
  - HRESP = 0.
  - Counter increments each cycle that IOREADY=0.
  - IOREADY & ~IOERROR: transfer completes this cycle. Next state is ACCESS if accept (back-to-back), else IDLE.
  - IOREADY & IOERROR -> ERR1.
  - IOREADY=0 with counter = TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0) -> ERR1.
- FSM, ERR1: HRESP=1, HREADYOUT=0. IOTRANS cleared. Unconditionally -> ERR2.
- FSM, ERR2: HRESP=1, HREADYOUT=1. Next state is ACCESS if accept, else IDLE.
  - The master may drive IDLE on HTRANS here to cancel a following transfer; no IOP access is then issued.
- Read data: HRDATA = IORDATA combinationally; valid only in the cycle where HREADYOUT=1 and HRESP=0 in ACCESS.
- Wait latency: 0 wait states if IOREADY is high in the first data-phase cycle; N wait states for N low cycles.
- Error and timeout priority:
  - IOERROR is ignored while IOREADY=0.
  - Timeout takes priority only when IOREADY=0 in that cycle.
  - A late IOREADY arriving in ERR1 or ERR2 is ignored.
- Counter width: clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- Reset mid-operation: all state clears immediately, the IOP transfer is abandoned, and HREADYOUT returns to 1.

Optional Feature:
- Macro: AHB_TO_IOP_RDATA_REG_EN.
- When defined:
  - Read data is captured into a DATA_WIDTH register on IOREADY & ~IOERROR & ~IOWRITE.
  - HREADYOUT is asserted one cycle later, via an extra RDHOLD state in which HREADYOUT=1 and HRDATA = registered value.
  - Reads gain one wait state; writes are unchanged.
  - The register resets to 0.
- When not defined: HRDATA = IORDATA combinationally; no RDHOLD state.

Test Plan:
- Write, zero wait: HADDR=0x014, HWRITE=1, HWDATA=0xDEADBEEF, IOREADY=1.
  -> Next cycle IOSEL=1, IOTRANS=1, IOADDR=0x014, IOWRITE=1, IOWDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0.
- Read, 3 wait states: IOREADY low for 3 cycles, then high with IORDATA=0x12345678.
  -> HREADYOUT=0 for 3 cycles, then 1 with HRDATA=0x12345678. IOADDR, IOWRITE and IOSIZE stable throughout.
- IOERROR: IOREADY=1 and IOERROR=1 in the first data cycle.
  -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE. IOTRANS=0 from ERR1.
- Timeout: TIMEOUT_CYCLES=4, IOREADY held 0.
  -> HREADYOUT=0 for 4 cycles, then ERR1, then ERR2. A second transfer issued in ERR2 is accepted, with IOADDR updated.
- Back-to-back: reads to 0x000 then 0x004, IOREADY=1.
  -> IOADDR goes 0x000 then 0x004 on consecutive edges and IOTRANS stays 1. With AHB_TO_IOP_RDATA_REG_EN, each read takes 2 cycles.
- Reset in ACCESS: HRESETn low while IOREADY=0.
  -> IOSEL, IOTRANS, IOADDR, IOWRITE and IOSIZE all go to 0 immediately, HREADYOUT=1, HRESP=0, state=IDLE.
